// File: rtl/raycaster_pkg.sv
// raycaster_pkg: shared raycaster constants, DDA result field layout and result struct.
//   SCREEN_WIDTH : columns per frame (even, <= 512)
//   COL_W        : column index width
//   DDA_TDATA_W  : DDA result beat width
//   *_LSB / *_BIT: field offsets inside a DDA result beat
//   dda_result_t : packed view of one DDA result beat
package raycaster_pkg;
   localparam int SCREEN_WIDTH = 320;
   localparam int COL_W        = 9;
   localparam int DDA_TDATA_W  = 39;
   localparam int COL_LSB      = 30;
   localparam int HEIGHT_LSB   = 21;
   localparam int TYPE_LSB     = 17;
   localparam int SIDE_BIT     = 16;
   typedef struct packed {
      logic [COL_W-1:0] col;
      logic [8:0]       height;
      logic [3:0]       wall_type;
      logic             side;
      logic [15:0]      wall_x;
   } dda_result_t;
endpackage

// File: rtl/dda_result_merger_axis_out_reg.sv
// axis_out_reg: one-deep AXI-Stream output register.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   load_in        : load data_in this cycle (only honoured when load_ok_out)
//   data_in        : beat to load
//   load_ok_out    : register is empty or being drained this cycle
//   tready_in      : downstream ready
//   tvalid_out     : registered beat valid
//   tdata_out      : registered beat
module axis_out_reg #(
   parameter int W = 40
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         load_in,
   input  logic [W-1:0] data_in,
   output logic         load_ok_out,
   input  logic         tready_in,
   output logic         tvalid_out,
   output logic [W-1:0] tdata_out
);
   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;
   always_comb begin
      load_ok_out = !valid_q || tready_in;
      load        = load_in && load_ok_out;
      valid_d     = load ? 1'b1 : (tready_in ? 1'b0 : valid_q);
      data_d      = load ? data_in : data_q;
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign tvalid_out = valid_q;
   assign tdata_out  = data_q;
endmodule

// File: rtl/dda_result_merger.sv
// dda_result_merger: merges even/odd-column DDA core results into one in-order AXI-Stream.
//   pixel_clk_in, rst_in        : clock, asynchronous active-high reset
//   core0_* (tvalid/tready/tdata): even-column results
//   core1_* (tvalid/tready/tdata): odd-column results
//   m_axis_* (tvalid/tready/tdata/tlast): merged stream, tlast on column SCREEN_WIDTH-1
//   frame_done_out              : pulse the cycle after the tlast beat is accepted
//   col_error_out               : sticky, an input col field differed from the expected column
module dda_result_merger
   import raycaster_pkg::*;
#(
   parameter int SCREEN_WIDTH = raycaster_pkg::SCREEN_WIDTH,
   parameter int TDATA_W      = raycaster_pkg::DDA_TDATA_W
) (
   input  logic               pixel_clk_in,
   input  logic               rst_in,
   input  logic               core0_tvalid_in,
   output logic               core0_tready_out,
   input  logic [TDATA_W-1:0] core0_tdata_in,
   input  logic               core1_tvalid_in,
   output logic               core1_tready_out,
   input  logic [TDATA_W-1:0] core1_tdata_in,
   output logic               m_axis_tvalid_out,
   input  logic               m_axis_tready_in,
   output logic [TDATA_W-1:0] m_axis_tdata_out,
   output logic               m_axis_tlast_out,
   output logic               frame_done_out,
   output logic               col_error_out
);
   logic [COL_W-1:0]   exp_col_q, exp_col_d;
   logic               err_q, err_d, done_q, done_d;
   logic               sel, ok_raw, load_ok, in_valid, accept, last_col;
   logic [TDATA_W-1:0] in_data;
   dda_result_t        beat;
   logic [TDATA_W:0]   out_w;
   always_comb begin
      sel       = exp_col_q[0];
      // ready is held low during reset so no beat is consumed and then dropped
      load_ok   = ok_raw && !rst_in;
      in_valid  = sel ? core1_tvalid_in : core0_tvalid_in;
      in_data   = sel ? core1_tdata_in : core0_tdata_in;
      accept    = in_valid && load_ok;
      last_col  = exp_col_q == COL_W'(SCREEN_WIDTH - 1);
      beat      = dda_result_t'(in_data);
      beat.col  = exp_col_q;
      exp_col_d = accept ? (last_col ? '0 : exp_col_q + 1'b1) : exp_col_q;
      err_d     = err_q || (accept && in_data[COL_LSB +: COL_W] != exp_col_q);
      done_d    = m_axis_tvalid_out && m_axis_tready_in && m_axis_tlast_out;
   end
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         exp_col_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         exp_col_q <= exp_col_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end
   axis_out_reg #(.W(TDATA_W + 1)) u_out (
      .clk_in     (pixel_clk_in),
      .rst_in     (rst_in),
      .load_in    (accept),
      .data_in    ({last_col, beat}),
      .load_ok_out(ok_raw),
      .tready_in  (m_axis_tready_in),
      .tvalid_out (m_axis_tvalid_out),
      .tdata_out  (out_w)
   );
   assign m_axis_tlast_out = out_w[TDATA_W];
   assign m_axis_tdata_out = out_w[TDATA_W-1:0];
   assign core0_tready_out = load_ok && !sel;
   assign core1_tready_out = load_ok && sel;
   assign frame_done_out   = done_q;
   assign col_error_out    = err_q;
endmodule

// File: tb/tb_dda_result_merger.sv
// tb_dda_result_merger: scoreboard bench for dda_result_merger.
module tb_dda_result_merger;
   localparam int SW = 320;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c0_v = 1'b0, c1_v = 1'b0, m_rdy = 1'b1;
   logic [38:0] c0_d = '0, c1_d = '0;
   logic        c0_r, c1_r, m_v, m_last, f_done, c_err;
   logic [38:0] m_d;
   logic [39:0] q[$];
   int          n_asrt = 0, n_fail = 0;
   int          m_exp = 0;
   int          cyc = 0, first_cyc = 0, last_done = 0, done_cnt = 0, done_gap = 0;
   logic        chk_tp = 1'b0, done_exp = 1'b0;

   always #5 clk = ~clk;

   dda_result_merger dut (
      .pixel_clk_in     (clk),
      .rst_in           (rst),
      .core0_tvalid_in  (c0_v),
      .core0_tready_out (c0_r),
      .core0_tdata_in   (c0_d),
      .core1_tvalid_in  (c1_v),
      .core1_tready_out (c1_r),
      .core1_tdata_in   (c1_d),
      .m_axis_tvalid_out(m_v),
      .m_axis_tready_in (m_rdy),
      .m_axis_tdata_out (m_d),
      .m_axis_tlast_out (m_last),
      .frame_done_out   (f_done),
      .col_error_out    (c_err)
   );

   // output monitor: scoreboard pop, frame_done timing, throughput, frame spacing
   always @(negedge clk) begin
      logic [39:0] e;
      cyc++;
      if (rst) done_exp = 1'b0;
      else begin
         n_asrt++;
         assert (f_done === done_exp) else begin
            n_fail++;
            $error("FAIL frame_done: got %b expected %b", f_done, done_exp);
         end
         if (f_done) begin
            if (done_cnt > 0) done_gap = cyc - last_done;
            last_done = cyc;
            done_cnt++;
         end
         done_exp = m_v && m_rdy && m_last;
         if (m_v && m_rdy) begin
            n_asrt++;
            assert (q.size() > 0) else begin
               n_fail++;
               $error("FAIL underflow: got beat %h expected none", m_d);
            end
            if (q.size() > 0) begin
               e = q.pop_front();
               n_asrt++;
               assert ({m_last, m_d} === e) else begin
                  n_fail++;
                  $error("FAIL beat: got %b/%h expected %b/%h", m_last, m_d, e[39], e[38:0]);
               end
               if (e[38:30] == 9'd0) first_cyc = cyc;
               if (e[39] && chk_tp) begin
                  n_asrt++;
                  assert (cyc - first_cyc == SW - 1) else begin
                     n_fail++;
                     $error("FAIL throughput: got %0d cycles expected %0d", cyc - first_cyc, SW - 1);
                  end
               end
            end
         end
      end
   end

   function automatic logic [38:0] mkd(input int idx, input int bad);
      int c;
      c = (idx == bad) ? idx + 2 : idx % SW;
      return {9'(c), 30'($urandom)};
   endfunction

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] expv);
      n_asrt++;
      assert (got === expv) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   task automatic chk_reset();
      chk("rst_tvalid", 40'(m_v), 40'd0);
      chk("rst_tdata", 40'(m_d), 40'd0);
      chk("rst_tlast", 40'(m_last), 40'd0);
      chk("rst_done", 40'(f_done), 40'd0);
      chk("rst_err", 40'(c_err), 40'd0);
      chk("rst_rdy0", 40'(c0_r), 40'd0);
      chk("rst_rdy1", 40'(c1_r), 40'd0);
   endtask

   // drive n beats, core0 even / core1 odd; optional stall on a column, corrupted column, early abort
   task automatic feed(input int n, input int stall_col, input int bad, input int abort_at);
      int i0 = 0, i1 = 1, acc = 0, stall = 0, guard = 0;
      logic stalled = 1'b0, hs0, hs1;
      logic [38:0] d0, d1, d;
      logic [39:0] held = '0;
      m_exp = 0;
      d0 = mkd(0, bad);
      d1 = mkd(1, bad);
      while (i0 < n || i1 < n) begin
         if (abort_at >= 0 && acc >= abort_at) break;
         if (guard++ > 4 * n + 100) begin
            chk("feed_timeout", 40'(guard), 40'(4 * n + 100));
            break;
         end
         @(posedge clk);
         #1;
         c0_v = i0 < n;
         c0_d = d0;
         c1_v = i1 < n;
         c1_d = d1;
         if (!stalled && stall_col >= 0 && m_v && m_d[38:30] == 9'(stall_col)) begin
            stalled = 1'b1;
            stall = 5;
            held = {m_last, m_d};
         end
         m_rdy = stall == 0;
         @(negedge clk);
         if (stall > 0) begin
            chk("stall_hold", {m_last, m_d}, held);
            chk("stall_rdy1", 40'(c1_r), 40'd0);
            chk("stall_rdy0", 40'(c0_r), 40'd0);
            stall--;
         end
         if (m_exp == 4 && c0_v && c1_v && m_rdy) begin
            chk("simul_rdy1", 40'(c1_r), 40'd0);
            chk("simul_rdy0", 40'(c0_r), 40'd1);
         end
         hs0 = c0_v && c0_r;
         hs1 = c1_v && c1_r;
         if (hs0 && hs1) chk("both_hs", 40'd1, 40'd0);
         if (hs0 || hs1) begin
            d = hs0 ? c0_d : c1_d;
            q.push_back({m_exp == SW - 1, 9'(m_exp), d[29:0]});
            m_exp = (m_exp == SW - 1) ? 0 : m_exp + 1;
            acc++;
            if (hs0) begin i0 += 2; d0 = mkd(i0, bad); end
            else begin i1 += 2; d1 = mkd(i1, bad); end
         end
      end
      @(posedge clk);
      #1;
      c0_v = 1'b0;
      c1_v = 1'b0;
      m_rdy = 1'b1;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 40'(q.size()), 40'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      // two back-to-back ideal frames
      chk_tp = 1'b1;
      done_cnt = 0;
      feed(2 * SW, -1, -1, -1);
      drain();
      repeat (3) @(negedge clk);
      chk("done_count", 40'(done_cnt), 40'd2);
      chk("done_gap", 40'(done_gap), 40'(SW));
      chk("no_err", 40'(c_err), 40'd0);
      // mid-frame reset
      chk_tp = 1'b0;
      feed(SW, -1, -1, 150);
      #3 rst = 1'b1;
      #1 chk_reset();
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      feed(SW, -1, -1, -1);
      drain();
      chk("no_err2", 40'(c_err), 40'd0);
      // backpressure on col 7 plus col 10 presented in place of col 8
      feed(SW, 7, 8, -1);
      drain();
      chk("err_set", 40'(c_err), 40'd1);
      repeat (10) @(negedge clk);
      chk("err_sticky", 40'(c_err), 40'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/dda_result_merger.md
# dda_result_merger

Merges the per-column results of the two DDA cores into the single in-order AXI-Stream that feeds the DDA-out FIFO (`ddr_fifo_wrap` sender side). It is the transmitter for the stream that the `transformation` module receives. Core 0 computes even columns and core 1 computes odd columns. The merger emits strictly ascending columns 0..SCREEN_WIDTH-1, asserts tlast on the final column of each frame, and buffers one beat so that backpressure from the FIFO never corrupts data.

## Interface
Parameters:
- SCREEN_WIDTH, 320, columns per frame; must be even and ≤ 512.
- TDATA_W, 39, beat width; fixed by the DDA result format.

Ports:
- pixel_clk_in  in  1  single clock for the block
- rst_in  in  1  asynchronous, active-high reset
- core0_tvalid_in  in  1  core 0 (even columns) result valid
- core0_tready_out  out  1  merger accepts core 0 beat
- core0_tdata_in  in  39  core 0 result: [38:30] col, [29:21] line height, [20:17] wall type, [16] side, [15:0] wall_x (U0.16)
- core1_tvalid_in  in  1  core 1 (odd columns) result valid
- core1_tready_out  out  1  merger accepts core 1 beat
- core1_tdata_in  in  39  core 1 result, same format
- m_axis_tvalid_out  out  1  beat valid toward FIFO
- m_axis_tready_in  in  1  FIFO ready (sender_axis_tready)
- m_axis_tdata_out  out  39  merged beat, same format
- m_axis_tlast_out  out  1  beat is column SCREEN_WIDTH-1
- frame_done_out  out  1  one-cycle pulse when the tlast beat is accepted downstream
- col_error_out  out  1  sticky: an input column field mismatched the expected column

## Operation
- Register `exp_col` (9 b) holds the next column to emit. Reset value 0.
- The selected core is `exp_col[0]`: 0 selects core 0, 1 selects core 1.
- Output register `load_ok = !m_axis_tvalid_out || m_axis_tready_in`.
- Only the selected core's tready_out equals load_ok. The other core's tready_out is 0.
- An input beat is accepted when the selected tvalid and tready are both high. On acceptance:
  - The output register loads the beat, with the col field overwritten by `exp_col`.
  - tlast is loaded as `exp_col == SCREEN_WIDTH-1`.
  - `exp_col` increments, wrapping from SCREEN_WIDTH-1 to 0.
  - If the input col field ≠ `exp_col`, col_error_out sets. It stays set until reset, and the beat is still forwarded.
- When the output is accepted with no new load, m_axis_tvalid_out clears.
- Both cores ready simultaneously: only the selected one is consumed. The other waits, with no loss.
- FIFO full (tready low): the output holds, tdata and tlast stay stable, and both core tready_out are 0.
- Reset mid-frame: all state clears asynchronously and the partial frame is dropped. After release, emission restarts at column 0.
- The cores must not present column n+2 before column n has been accepted. The merger does no reordering.

## Timing
- Reset values: m_axis_tvalid_out=0, m_axis_tdata_out=0, m_axis_tlast_out=0, frame_done_out=0, col_error_out=0, core*_tready_out=0 while rst_in is high.
- Latency: input accept on cycle N gives m_axis_tvalid_out high on N+1.
- Throughput: 1 beat/cycle when the cores alternate valid and tready stays high. A frame takes SCREEN_WIDTH cycles minimum.
- tready_out is combinational from m_axis_tready_in and m_axis_tvalid_out. It has no dependency on core tvalid.
- frame_done_out is registered: high the cycle after a tvalid&&tready&&tlast handshake.
- AXI rule: once tvalid_out rises, tdata and tlast do not change until tready_in is sampled high.

## Structure
- Shared package `raycaster_pkg`:
  - SCREEN_WIDTH, COL_W=9, DDA_TDATA_W=39
  - field offset localparams (COL_LSB=30, HEIGHT_LSB=21, TYPE_LSB=17, SIDE_BIT=16)
  - packed struct `dda_result_t`, also consumed by `transformation`
- One sub-module: `axis_out_reg`, a one-deep AXI-Stream output register with load_ok logic, TDATA_W+1 wide to carry tlast.
- Selection, column counter and error logic live in the top of this block.

## Test plan
- Reset then ideal stream: cores alternate cols 0..319, tready=1 -> 320 beats, cols ascending 0..319, tlast only on 319, frame_done_out pulses once the cycle after, no idle cycles.
- Backpressure: tready=0 for 5 cycles while col 7 is held -> tdata/tlast stable, core1_tready_out=0 throughout. Col 8 emitted after tready returns, nothing lost or duplicated.
- Simultaneous valid: core0 presents col 4 and core1 presents col 5 in the same cycle at exp_col=4 -> col 4 accepted first, col 5 the next cycle, core1 held one cycle.
- Mismatch: core0 presents col 10 when exp_col=8 -> beat emitted with col field 8, col_error_out=1 and remains 1 for the rest of the run.
- Wrap: two back-to-back frames -> second frame starts at col 0, two frame_done_out pulses 320 beats apart.
- Mid-frame reset: assert rst_in at col 150 -> outputs go to reset values immediately. After release, the first emitted beat is col 0 with tlast=0.
